can_rx_error_signaler: RTL and testbench

Receive-side error signalling block for the CAN message validator. It accepts error pulses from the receive path and drives a CAN error frame onto the transmit-bit path, one bit per `bit_tick`. Each frame is an error flag followed by flag superposition and an 8-bit recessive delimiter. It also maintains the receive error counter (REC) and the error-active/error-passive state, and is the receiver counterpart of the transmit retransmission logic.

---
 rtl/can_pkg.sv | 52 +++++
 rtl/can_rx_error_signaler_if.sv | 28 ++
 rtl/can_error_counter.sv | 54 +++++
 rtl/can_rx_error_signaler.sv | 191 +++++++++++++++++++
 tb/tb_can_rx_error_signaler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared types, REC step constants and small helpers for the CAN receive
// error signalling block.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLAG     = 2'd1,
    SUPERPOS = 2'd2,
    DELIM    = 2'd3
  } err_state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_STUFF = 3'd1,
    ERR_FORM  = 3'd2,
    ERR_CRC   = 3'd3,
    ERR_BIT   = 3'd4
  } err_code_t;

  localparam logic [8:0] REC_INC            = 9'd1;
  localparam logic [8:0] REC_INC_FLAG       = 9'd8;
  localparam logic [7:0] REC_PASSIVE_RELOAD = 8'd120;
  localparam logic [8:0] REC_MAX            = 9'd255;

  // Add a step to REC in 9 bits and clamp at 255.
  function automatic logic [7:0] rec_sat_add(input logic [7:0] rec, input logic [8:0] step);
    logic [8:0] sum;
    sum = {1'b0, rec} + step;
    if (sum > REC_MAX) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

  // Coinciding pulses collapse to one code: bit > stuff > form > crc.
  function automatic err_code_t err_priority(input logic b, input logic s,
                                             input logic f, input logic c);
    if (b) begin
      return ERR_BIT;
    end else if (s) begin
      return ERR_STUFF;
    end else if (f) begin
      return ERR_FORM;
    end else if (c) begin
      return ERR_CRC;
    end else begin
      return ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/can_rx_error_signaler_if.sv
// Bus bundle between the receive path and the error signaller.
interface can_rx_error_signaler_if;
  logic       enable;
  logic       bit_tick;
  logic       rx_bit;
  logic       stuff_error;
  logic       form_error;
  logic       crc_error;
  logic       bit_error;
  logic       rx_frame_valid;
  logic       tx_bit;
  logic       error_frame_active;
  logic       error_passive;
  logic [7:0] rec;
  logic [2:0] last_error_code;

  modport master (
    output enable, bit_tick, rx_bit, stuff_error, form_error, crc_error,
           bit_error, rx_frame_valid,
    input  tx_bit, error_frame_active, error_passive, rec, last_error_code
  );

  modport slave (
    input  enable, bit_tick, rx_bit, stuff_error, form_error, crc_error,
           bit_error, rx_frame_valid,
    output tx_bit, error_frame_active, error_passive, rec, last_error_code
  );
endinterface

// File: rtl/can_error_counter.sv
// Receive error counter: saturating increments, frame-valid decrement with
// passive reload, and the error-passive compare.
module can_error_counter
  import can_pkg::*;
#(
  parameter int PASSIVE_LIMIT = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc_one,
  input  logic       inc_flag,
  input  logic       dec,
  output logic [7:0] rec,
  output logic       error_passive
);

  logic [7:0] rec_r;
  logic [7:0] rec_n;
  logic       passive_s;

  assign passive_s     = ({1'b0, rec_r} >= 9'(PASSIVE_LIMIT));
  assign rec           = rec_r;
  assign error_passive = passive_s;

  // Next REC value; the caller never raises both increments together.
  always_comb begin
    rec_n = rec_r;
    if (inc_flag) begin
      rec_n = rec_sat_add(rec_r, REC_INC_FLAG);
    end else if (inc_one) begin
      rec_n = rec_sat_add(rec_r, REC_INC);
    end else if (dec) begin
      if (passive_s) begin
        rec_n = REC_PASSIVE_RELOAD;
      end else if (rec_r != 8'd0) begin
        rec_n = rec_r - 8'd1;
      end else begin
        rec_n = rec_r;
      end
    end else begin
      rec_n = rec_r;
    end
  end

  // REC register; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rec_r <= 8'd0;
    end else begin
      rec_r <= rec_n;
    end
  end

endmodule

// File: rtl/can_rx_error_signaler.sv
// Receive-side CAN error frame generator: error flag, superposition wait and
// recessive delimiter, one bit per bit_tick, plus REC bookkeeping.
module can_rx_error_signaler
  import can_pkg::*;
#(
  parameter int FLAG_BITS     = 6,
  parameter int DELIM_BITS    = 8,
  parameter int PASSIVE_LIMIT = 128
) (
  input logic clock,
  input logic reset,
  can_rx_error_signaler_if.slave bus
);

  localparam int CNT_W = $clog2(FLAG_BITS + DELIM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_BITS);
  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_BITS - 1);

  err_state_t       state_r, state_n;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_n;
  logic [2:0]       dom_cnt_r, dom_cnt_n;
  logic             first_dom_r, first_dom_n;
  logic             tx_bit_r, tx_bit_n;
  logic             flag_passive_r, flag_passive_n;
  logic             pending_r, pending_n;
  err_code_t        code_r, code_n;
  err_code_t        pulse_code_s;
  logic             any_err_s, accept_s;
  logic             inc_one_s, inc_flag_s, dec_s;
  logic [7:0]       rec_s;
  logic             passive_s;

  assign any_err_s    = bus.bit_error | bus.stuff_error | bus.form_error | bus.crc_error;
  assign pulse_code_s = err_priority(bus.bit_error, bus.stuff_error, bus.form_error, bus.crc_error);
  assign accept_s     = any_err_s && ((state_r == IDLE) || (state_r == DELIM));

  can_error_counter #(.PASSIVE_LIMIT(PASSIVE_LIMIT)) u_rec (
    .clock         (clock),
    .reset         (reset),
    .inc_one       (inc_one_s & bus.enable),
    .inc_flag      (inc_flag_s & bus.enable),
    .dec           (dec_s & bus.enable),
    .rec           (rec_s),
    .error_passive (passive_s)
  );

  assign bus.tx_bit             = tx_bit_r;
  assign bus.error_frame_active = (state_r != IDLE);
  assign bus.error_passive      = passive_s;
  assign bus.rec                = rec_s;
  assign bus.last_error_code    = code_r;

  // Next-state, bit counters, tx bit and REC event strobes.
  always_comb begin
    state_n        = state_r;
    bit_cnt_n      = bit_cnt_r;
    dom_cnt_n      = dom_cnt_r;
    first_dom_n    = first_dom_r;
    tx_bit_n       = tx_bit_r;
    flag_passive_n = flag_passive_r;
    pending_n      = pending_r;
    code_n         = code_r;
    inc_one_s      = 1'b0;
    inc_flag_s     = 1'b0;
    // A coinciding error pulse wins over the frame-valid decrement.
    dec_s          = bus.rx_frame_valid && (state_r == IDLE) && !accept_s;

    if (accept_s) begin
      pending_n = 1'b1;
      code_n    = pulse_code_s;
      inc_one_s = 1'b1;
    end else begin
      pending_n = pending_r;
    end

    case (state_r)
      IDLE: begin
        if (bus.bit_tick && pending_r) begin
          state_n        = FLAG;
          bit_cnt_n      = CNT_ONE;
          tx_bit_n       = passive_s;
          flag_passive_n = passive_s;
          pending_n      = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      FLAG: begin
        if (bus.bit_tick) begin
          if (!flag_passive_r && bus.rx_bit) begin
            inc_flag_s = 1'b1;
          end else begin
            inc_flag_s = 1'b0;
          end
          if (bit_cnt_r == FLAG_LAST) begin
            state_n     = SUPERPOS;
            tx_bit_n    = 1'b1;
            first_dom_n = 1'b1;
            dom_cnt_n   = 3'd0;
            bit_cnt_n   = CNT_ZERO;
          end else begin
            bit_cnt_n = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_n = FLAG;
        end
      end
      SUPERPOS: begin
        if (bus.bit_tick) begin
          if (bus.rx_bit) begin
            // This recessive bit is delimiter bit 1.
            state_n   = DELIM;
            bit_cnt_n = CNT_ONE;
            tx_bit_n  = 1'b1;
          end else if (first_dom_r) begin
            inc_flag_s  = 1'b1;
            first_dom_n = 1'b0;
            dom_cnt_n   = 3'd0;
          end else if (dom_cnt_r == 3'd7) begin
            inc_flag_s = 1'b1;
            dom_cnt_n  = 3'd0;
          end else begin
            dom_cnt_n = dom_cnt_r + 3'd1;
          end
        end else begin
          state_n = SUPERPOS;
        end
      end
      DELIM: begin
        if (bus.bit_tick) begin
          if (!bus.rx_bit) begin
            // Corrupted delimiter: form error, restart the flag immediately.
            state_n        = FLAG;
            bit_cnt_n      = CNT_ONE;
            tx_bit_n       = passive_s;
            flag_passive_n = passive_s;
            inc_one_s      = 1'b1;
            code_n         = ERR_FORM;
            pending_n      = 1'b0;
          end else if (bit_cnt_r == DELIM_LAST) begin
            state_n   = IDLE;
            bit_cnt_n = CNT_ZERO;
          end else begin
            bit_cnt_n = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_n = DELIM;
        end
      end
      default: begin
        state_n  = IDLE;
        tx_bit_n = 1'b1;
      end
    endcase
  end

  // State register; enable low resets everything except REC and the code.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      bit_cnt_r      <= CNT_ZERO;
      dom_cnt_r      <= 3'd0;
      first_dom_r    <= 1'b0;
      tx_bit_r       <= 1'b1;
      flag_passive_r <= 1'b0;
      pending_r      <= 1'b0;
      code_r         <= ERR_NONE;
    end else if (!bus.enable) begin
      state_r        <= IDLE;
      bit_cnt_r      <= CNT_ZERO;
      dom_cnt_r      <= 3'd0;
      first_dom_r    <= 1'b0;
      tx_bit_r       <= 1'b1;
      flag_passive_r <= 1'b0;
      pending_r      <= 1'b0;
      code_r         <= code_r;
    end else begin
      state_r        <= state_n;
      bit_cnt_r      <= bit_cnt_n;
      dom_cnt_r      <= dom_cnt_n;
      first_dom_r    <= first_dom_n;
      tx_bit_r       <= tx_bit_n;
      flag_passive_r <= flag_passive_n;
      pending_r      <= pending_n;
      code_r         <= code_n;
    end
  end

endmodule

// File: tb/tb_can_rx_error_signaler.sv
// Directed, table-driven bench for can_rx_error_signaler.
module tb_can_rx_error_signaler;
  import can_pkg::*;

  typedef struct {
    logic rx;
    logic exp_tx;
    logic exp_efa;
  } frame_vec_t;

  typedef struct {
    logic       b;
    logic       s;
    logic       f;
    logic       c;
    logic [2:0] exp_code;
  } prio_vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  frame_vec_t frame_tbl [15];
  prio_vec_t  prio_tbl  [4];

  can_rx_error_signaler_if bus();

  can_rx_error_signaler #(
    .FLAG_BITS     (6),
    .DELIM_BITS    (8),
    .PASSIVE_LIMIT (128)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One bit time: strobe bit_tick with rx for one cycle, then two idle cycles.
  task automatic tick(input logic rx);
    @(negedge clock);
    bus.bit_tick = 1'b1;
    bus.rx_bit   = rx;
    @(posedge clock);
    #1;
    bus.bit_tick = 1'b0;
    bus.rx_bit   = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic pulse(input logic b, input logic s, input logic f, input logic c, input logic v);
    @(negedge clock);
    bus.bit_error      = b;
    bus.stuff_error    = s;
    bus.form_error     = f;
    bus.crc_error      = c;
    bus.rx_frame_valid = v;
    @(posedge clock);
    #1;
    bus.bit_error      = 1'b0;
    bus.stuff_error    = 1'b0;
    bus.form_error     = 1'b0;
    bus.crc_error      = 1'b0;
    bus.rx_frame_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (bus.error_frame_active && n < 40) begin
      tick(1'b1);
      n++;
    end
    check(name, int'(bus.error_frame_active), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int efa_ticks;

    // Active error frame, bus echoing our own flag, no superposition.
    frame_tbl[0] = '{1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= 5; i++) frame_tbl[i] = '{1'b0, 1'b0, 1'b1};
    frame_tbl[6] = '{1'b0, 1'b1, 1'b1};
    for (int i = 7; i <= 13; i++) frame_tbl[i] = '{1'b1, 1'b1, 1'b1};
    frame_tbl[14] = '{1'b1, 1'b1, 1'b0};

    prio_tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd4};
    prio_tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
    prio_tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
    prio_tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3};

    bus.enable = 1'b1;
    bus.bit_tick = 1'b0;
    bus.rx_bit = 1'b1;
    bus.stuff_error = 1'b0;
    bus.form_error = 1'b0;
    bus.crc_error = 1'b0;
    bus.bit_error = 1'b0;
    bus.rx_frame_valid = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", int'(bus.tx_bit), 1);
    check("reset_efa", int'(bus.error_frame_active), 0);
    check("reset_passive", int'(bus.error_passive), 0);
    check("reset_rec", int'(bus.rec), 0);
    check("reset_code", int'(bus.last_error_code), 0);
    @(negedge clock);
    reset = 1'b0;
    tick(1'b1);
    tick(1'b1);
    check("idle_efa", int'(bus.error_frame_active), 0);

    // Active stuff error frame, 14 bit times.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stuff_rec", int'(bus.rec), 1);
    check("stuff_code", int'(bus.last_error_code), 1);
    check("stuff_efa_before_tick", int'(bus.error_frame_active), 0);
    efa_ticks = 0;
    for (int i = 0; i < 15; i++) begin
      tick(frame_tbl[i].rx);
      check($sformatf("frame_tx[%0d]", i), int'(bus.tx_bit), int'(frame_tbl[i].exp_tx));
      check($sformatf("frame_efa[%0d]", i), int'(bus.error_frame_active), int'(frame_tbl[i].exp_efa));
      if (bus.error_frame_active) efa_ticks++;
    end
    check("frame_len", efa_ticks, 14);
    check("frame_rec", int'(bus.rec), 1);

    // Priority of coinciding pulses.
    for (int i = 0; i < 4; i++) begin
      pulse(prio_tbl[i].b, prio_tbl[i].s, prio_tbl[i].f, prio_tbl[i].c, 1'b0);
      check($sformatf("prio_code[%0d]", i), int'(bus.last_error_code), int'(prio_tbl[i].exp_code));
      check($sformatf("prio_rec[%0d]", i), int'(bus.rec), 2 + i);
      finish_frame("prio_frame_end");
    end

    // crc+form with rx_frame_valid at REC=5: error wins.
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("simul_rec", int'(bus.rec), 6);
    check("simul_code", int'(bus.last_error_code), 2);
    finish_frame("simul_frame_end");
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("dec_rec", int'(bus.rec), 5);

    // Pulses in FLAG ignored; frame-valid outside IDLE ignored.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    tick(1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flag_ignore_rec", int'(bus.rec), 6);
    check("flag_ignore_code", int'(bus.last_error_code), 1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flag_valid_rec", int'(bus.rec), 6);
    repeat (5) tick(1'b0);
    check("flag_done_tx", int'(bus.tx_bit), 1);
    finish_frame("ignore_frame_end");

    // Dominant after own flag, from REC=0.
    do_reset();
    check("reset2_rec", int'(bus.rec), 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    repeat (6) tick(1'b0);
    repeat (3) tick(1'b0);
    check("superpos_rec", int'(bus.rec), 9);
    check("superpos_tx", int'(bus.tx_bit), 1);
    check("superpos_efa", int'(bus.error_frame_active), 1);
    repeat (7) tick(1'b1);
    check("superpos_delim7_efa", int'(bus.error_frame_active), 1);
    tick(1'b1);
    check("superpos_delim8_efa", int'(bus.error_frame_active), 0);
    check("superpos_end_rec", int'(bus.rec), 9);

    // First dominant +8, then a further run of 8 dominant bits +8.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    repeat (6) tick(1'b0);
    repeat (8) tick(1'b0);
    check("run7_rec", int'(bus.rec), 18);
    tick(1'b0);
    check("run8_rec", int'(bus.rec), 26);
    finish_frame("run_frame_end");

    // Dominant on delimiter bit 4.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    repeat (6) tick(1'b0);
    repeat (3) tick(1'b1);
    tick(1'b0);
    check("delim_err_rec", int'(bus.rec), 28);
    check("delim_err_code", int'(bus.last_error_code), 2);
    check("delim_err_tx", int'(bus.tx_bit), 0);
    check("delim_err_efa", int'(bus.error_frame_active), 1);
    repeat (5) tick(1'b0);
    check("reflag_tx5", int'(bus.tx_bit), 0);
    tick(1'b0);
    check("reflag_tx6", int'(bus.tx_bit), 1);
    finish_frame("reflag_frame_end");
    check("reflag_rec", int'(bus.rec), 28);

    // Passive flag and reload.
    do_reset();
    for (int i = 0; i < 128; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("preload_rec", int'(bus.rec), 128);
    check("preload_passive", int'(bus.error_passive), 1);
    tick(1'b1);
    check("passive_flag_efa", int'(bus.error_frame_active), 1);
    check("passive_flag_tx", int'(bus.tx_bit), 1);
    repeat (6) tick(1'b1);
    check("passive_flag_rec", int'(bus.rec), 128);
    finish_frame("passive_frame_end");
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reload_rec", int'(bus.rec), 120);
    check("reload_passive", int'(bus.error_passive), 0);

    // Saturation at 255, then reload from 255.
    for (int i = 0; i < 140; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_rec", int'(bus.rec), 255);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_reload_rec", int'(bus.rec), 120);

    // REC 0 decrement, pulse coinciding with bit_tick, reset mid-flag.
    do_reset();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("dec_zero_rec", int'(bus.rec), 0);
    @(negedge clock);
    bus.stuff_error = 1'b1;
    bus.bit_tick = 1'b1;
    bus.rx_bit = 1'b1;
    @(posedge clock);
    #1;
    bus.stuff_error = 1'b0;
    bus.bit_tick = 1'b0;
    check("coinc_efa", int'(bus.error_frame_active), 0);
    check("coinc_rec", int'(bus.rec), 1);
    tick(1'b1);
    check("coinc_next_efa", int'(bus.error_frame_active), 1);
    check("coinc_next_tx", int'(bus.tx_bit), 0);
    tick(1'b0);
    tick(1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_tx", int'(bus.tx_bit), 1);
    check("midreset_efa", int'(bus.error_frame_active), 0);
    check("midreset_rec", int'(bus.rec), 0);
    @(negedge clock);
    reset = 1'b0;

    // Disable mid-flag.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("pre_disable_tx", int'(bus.tx_bit), 0);
    @(negedge clock);
    bus.enable = 1'b0;
    @(posedge clock);
    #1;
    check("disable_tx", int'(bus.tx_bit), 1);
    check("disable_efa", int'(bus.error_frame_active), 0);
    check("disable_rec", int'(bus.rec), 1);
    check("disable_code", int'(bus.last_error_code), 1);
    @(negedge clock);
    bus.enable = 1'b1;
    tick(1'b1);
    tick(1'b1);
    check("reenable_efa", int'(bus.error_frame_active), 0);
    check("reenable_tx", int'(bus.tx_bit), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
